// File: rtl/om_timing_est_core_if.sv
// rtl/om_timing_est_core_if.sv - sample-in / estimate-out handshake bundle for om_timing_est_core (OM_MAG_OUT_EN adds m_mag)
interface om_timing_est_core_if #(
  parameter int DW    = 16,
  parameter int EPS_W = 12
`ifdef OM_MAG_OUT_EN
  , parameter int MAG_W = 38
`endif
);
  logic signed [DW-1:0]    s_i;
  logic signed [DW-1:0]    s_q;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [EPS_W-1:0] m_eps;
  logic                    m_valid;
  logic                    m_ready;
`ifdef OM_MAG_OUT_EN
  logic [MAG_W-1:0]        m_mag;
`endif

  // Sample source and estimate sink side
  modport master (
    output s_i, s_q, s_valid, m_ready,
`ifdef OM_MAG_OUT_EN
    input  m_mag,
`endif
    input  s_ready, m_eps, m_valid
  );

  // Estimator core side
  modport slave (
    input  s_i, s_q, s_valid, m_ready,
`ifdef OM_MAG_OUT_EN
    output m_mag,
`endif
    output s_ready, m_eps, m_valid
  );
endinterface

// File: rtl/om_timing_est_core.sv
// rtl/om_timing_est_core.sv - Oerder-Meyr timing estimator, 4 sps, vectoring CORDIC arg; macro OM_MAG_OUT_EN adds m_mag
module om_timing_est_core #(
  parameter int DW        = 16,
  parameter int L_SYM     = 64,
  parameter int EPS_W     = 12,
  parameter int CORDIC_IT = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  om_timing_est_core_if.slave  bus
);
  localparam int ACC_W = 2 * DW + 3 + $clog2(L_SYM);
  localparam int XW    = ACC_W + 1;           // one guard bit for CORDIC growth
  localparam int ZF    = 8;                   // fractional angle bits below the eps LSB
  localparam int ZW    = EPS_W + ZF;
  localparam int SH    = 32 - ZW;             // table is 2^32 per turn
  localparam int P_W   = 2 * DW + 1;
  localparam int CNT_W = $clog2(4 * L_SYM);

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(4 * L_SYM - 1);
  localparam logic [4:0]           IT_LAST  = 5'(CORDIC_IT - 1);
  localparam logic signed [ZW-1:0] Z_HALF   = {1'b1, {(ZW - 1){1'b0}}};

  typedef enum logic [1:0] {ST_ACC, ST_ROT, ST_OUT} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc_re;
  logic signed [ACC_W-1:0] acc_im;
  logic signed [XW-1:0]    x_r;
  logic signed [XW-1:0]    y_r;
  logic signed [ZW-1:0]    z_r;
  logic [4:0]              it_cnt;
  logic                    loaded;
  logic                    is_zero;
  logic                    s_ready_r;
  logic                    m_valid_r;
  logic signed [EPS_W-1:0] m_eps_r;
`ifdef OM_MAG_OUT_EN
  logic [XW-1:0]           m_mag_r;
`endif

  logic signed [2*DW-1:0]  sq_i;
  logic signed [2*DW-1:0]  sq_q;
  logic [P_W-1:0]          pwr;
  logic signed [ACC_W-1:0] pwr_ext;
  logic signed [XW-1:0]    re_ext;
  logic signed [XW-1:0]    im_ext;
  logic signed [XW-1:0]    x_sh;
  logic signed [XW-1:0]    y_sh;
  logic signed [XW-1:0]    x_nx;
  logic signed [XW-1:0]    y_nx;
  logic signed [ZW-1:0]    z_nx;
  logic signed [ZW-1:0]    ang;
  logic signed [ZW-1:0]    neg_z;

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_eps   = m_eps_r;
`ifdef OM_MAG_OUT_EN
  assign bus.m_mag   = m_mag_r;
`endif

  // atan(2^-i) in turns, 2^32 per turn, rounded to the z grid
  function automatic logic signed [ZW-1:0] atan_lsb(input logic [4:0] i);
    logic [31:0] t;
    case (i)
      5'd0:    t = 32'd536870912;
      5'd1:    t = 32'd316933406;
      5'd2:    t = 32'd167458907;
      5'd3:    t = 32'd85004756;
      5'd4:    t = 32'd42667331;
      5'd5:    t = 32'd21354465;
      5'd6:    t = 32'd10679838;
      5'd7:    t = 32'd5340245;
      5'd8:    t = 32'd2670163;
      5'd9:    t = 32'd1335087;
      5'd10:   t = 32'd667544;
      5'd11:   t = 32'd333772;
      5'd12:   t = 32'd166886;
      5'd13:   t = 32'd83443;
      5'd14:   t = 32'd41722;
      5'd15:   t = 32'd20861;
      default: t = 32'd0;
    endcase
    atan_lsb = ZW'((t + (32'd1 << (SH - 1))) >> SH);
  endfunction

  // Instantaneous power of the offered sample and sign-extended accumulator views
  always_comb begin
    sq_i    = bus.s_i * bus.s_i;
    sq_q    = bus.s_q * bus.s_q;
    pwr     = P_W'($unsigned(sq_i)) + P_W'($unsigned(sq_q));
    pwr_ext = $signed(ACC_W'(pwr));
    re_ext  = {acc_re[ACC_W-1], acc_re};
    im_ext  = {acc_im[ACC_W-1], acc_im};
  end

  // One vectoring micro-rotation: steer y toward zero, z collects arg(X)
  always_comb begin
    x_sh = x_r >>> it_cnt;
    y_sh = y_r >>> it_cnt;
    ang  = atan_lsb(it_cnt);
    if (y_r[XW-1]) begin
      x_nx = x_r - y_sh;
      y_nx = y_r + x_sh;
      z_nx = z_r - ang;
    end else begin
      x_nx = x_r + y_sh;
      y_nx = y_r - x_sh;
      z_nx = z_r + ang;
    end
    neg_z = -z_nx;
  end

  // Block accumulation, CORDIC sequencing and output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      cnt       <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      it_cnt    <= '0;
      loaded    <= 1'b0;
      is_zero   <= 1'b0;
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
      m_eps_r   <= '0;
`ifdef OM_MAG_OUT_EN
      m_mag_r   <= '0;
`endif
    end else begin
      case (state)
        ST_ACC: begin
          if (bus.s_valid && s_ready_r) begin
            // k is the low two bits of the block sample counter
            case (cnt[1:0])
              2'd0:    acc_re <= acc_re + pwr_ext;
              2'd1:    acc_im <= acc_im - pwr_ext;
              2'd2:    acc_re <= acc_re - pwr_ext;
              default: acc_im <= acc_im + pwr_ext;
            endcase
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= ST_ROT;
              s_ready_r <= 1'b0;
              loaded    <= 1'b0;
            end
          end
        end
        ST_ROT: begin
          if (!loaded) begin
            // Left half-plane vectors are pre-rotated by half a turn
            if (acc_re[ACC_W-1]) begin
              x_r <= -re_ext;
              y_r <= -im_ext;
              z_r <= Z_HALF;
            end else begin
              x_r <= re_ext;
              y_r <= im_ext;
              z_r <= '0;
            end
            is_zero <= (acc_re == '0) && (acc_im == '0);
            it_cnt  <= '0;
            loaded  <= 1'b1;
          end else begin
            x_r    <= x_nx;
            y_r    <= y_nx;
            z_r    <= z_nx;
            it_cnt <= it_cnt + 1'b1;
            if (it_cnt == IT_LAST) begin
              // A null vector has no angle; report zero offset
              m_eps_r   <= is_zero ? '0 : EPS_W'(neg_z >>> ZF);
`ifdef OM_MAG_OUT_EN
              m_mag_r   <= x_nx;
`endif
              m_valid_r <= 1'b1;
              state     <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (bus.m_ready) begin
            m_valid_r <= 1'b0;
            acc_re    <= '0;
            acc_im    <= '0;
            cnt       <= '0;
            s_ready_r <= 1'b1;
            state     <= ST_ACC;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_om_timing_est_core.sv
// tb/tb_om_timing_est_core.sv - directed-vector bench for om_timing_est_core (m_mag checked when OM_MAG_OUT_EN is defined)
`timescale 1ns/1ps
module tb_om_timing_est_core;
  localparam int DW        = 16;
  localparam int L_SYM     = 4;
  localparam int EPS_W     = 12;
  localparam int CORDIC_IT = 12;
  localparam int NBLK      = 4 * L_SYM;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // 100 MHz clock
  always #5 clk = ~clk;

  om_timing_est_core_if #(.DW(DW), .EPS_W(EPS_W)) bus ();

  om_timing_est_core #(
    .DW(DW), .L_SYM(L_SYM), .EPS_W(EPS_W), .CORDIC_IT(CORDIC_IT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol = 0);
    longint d;
    n_tests++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/- %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int q);
    int n;
    bus.s_i     = 16'(i);
    bus.s_q     = 16'(q);
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.s_ready) check_val("send_timeout", 0, 1);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic send_block(input int hot, input int amp, input int gap);
    for (int j = 0; j < NBLK; j++) begin
      send(((j % 4) == hot) ? amp : 0, 0);
      if (j < NBLK - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.m_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic accept();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check_val("acc_mvalid_lo", longint'(bus.m_valid), 0);
    check_val("acc_sready_hi", longint'(bus.s_ready), 1);
  endtask

  // Feed one block, check backpressure, latency and the estimate; leaves the estimate pending
  task automatic run_block(input string tag, input int hot, input int amp, input int gap,
                           input longint exp, input longint tol);
    int cyc;
    send_block(hot, amp, gap);
    check_val({tag, "_sready_lo"}, longint'(bus.s_ready), 0);
    wait_valid(cyc);
    check_val({tag, "_latency"}, longint'(cyc), longint'(CORDIC_IT + 1));
    check_val({tag, "_eps"}, longint'(bus.m_eps), exp, tol);
  endtask

  initial begin
    bus.s_i     = '0;
    bus.s_q     = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    rst_n       = 1'b0;
    repeat (3) tick();
    check_val("rst_sready", longint'(bus.s_ready), 1);
    check_val("rst_mvalid", longint'(bus.m_valid), 0);
    check_val("rst_eps", longint'(bus.m_eps), 0);
`ifdef OM_MAG_OUT_EN
    check_val("rst_mag", longint'(bus.m_mag), 0);
`endif
    rst_n = 1'b1;
    tick();

    // Energy at k=0: X = +P, zero offset
    run_block("k0", 0, 1000, 0, 0, 1);
`ifdef OM_MAG_OUT_EN
    check_val("k0_mag", longint'(bus.m_mag), 64'd6587200, 64'd6587);
`endif
    accept();

    // Energy at k=1: X = -jP, quarter symbol late
    run_block("k1", 1, 1000, 0, 1024, 1);
    accept();

    // Energy at k=3 with s_valid gaps between samples
    run_block("k3gap", 3, 1000, 2, -1024, 1);
    accept();

    // Energy at k=2: X = -P, half-turn wraps to the most negative code
    run_block("k2", 2, 1000, 0, -2048, 0);
    accept();

    // Null block
    run_block("zero", -1, 0, 0, 0, 0);
    accept();

    // Output held against backpressure while a sample is offered
    run_block("hold", 1, 1000, 0, 1024, 1);
    bus.s_i     = 16'sd5000;
    bus.s_q     = 16'sd0;
    bus.s_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val("hold_mvalid", longint'(bus.m_valid), 1);
      check_val("hold_eps", longint'(bus.m_eps), 1024, 1);
      check_val("hold_sready", longint'(bus.s_ready), 0);
    end
    bus.s_valid = 1'b0;
    accept();

    // Phase alignment intact after the hold
    run_block("post_hold", 3, 1000, 0, -1024, 1);
    accept();

    // Reset aborts a partial block
    for (int j = 0; j < 9; j++) send(((j % 4) == 2) ? 30000 : 0, 7000);
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_sready", longint'(bus.s_ready), 1);
    check_val("mid_rst_mvalid", longint'(bus.m_valid), 0);
    check_val("mid_rst_eps", longint'(bus.m_eps), 0);
    rst_n = 1'b1;
    run_block("after_rst", 1, 1000, 0, 1024, 1);
    accept();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
